// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers, start/busy handshake and exception abort.
// Optional multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU) are enabled by defining MD_MADD_EN.
module md_unit #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             req,
   input  logic             rd_hi,
   output logic             busy,
   output logic             stall,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic [WIDTH-1:0] rdata
);

   localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);

   localparam logic IDLE = 1'b0;
   localparam logic RUN  = 1'b1;

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9;
   localparam logic [3:0] OP_MSUBU = 4'd10;

   logic                 state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
   logic [2*WIDTH-1:0]   pend_q, pend_d;
   logic                 pendValid_q, pendValid_d;

   logic                 isMul, isDiv, isMadd, accept;
   logic [2*WIDTH-1:0]   extA, extB, prodS, prodU, accVal, result;
   logic                 resultWe;
   logic [WIDTH-1:0]     divisor, absA, absB, quoMag, remMag, quoS, remS, quoU, remU;

   always_comb begin
      isMadd = 1'b0;
`ifdef MD_MADD_EN
      isMadd = (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`endif
      isMul = (op == OP_MULT) || (op == OP_MULTU) || isMadd;
      isDiv = (op == OP_DIV) || (op == OP_DIVU);
   end

   assign accept = start && !req && (state_q == IDLE);
   assign busy   = (state_q == RUN);
   assign stall  = busy || (start && (isMul || isDiv));
   assign hi_out = hi_q;
   assign lo_out = lo_q;
   assign rdata  = rd_hi ? hi_q : lo_q;

   // Divisor forced to 1 on zero so the datapath never produces X; the write is suppressed anyway.
   always_comb begin
      extA    = {{WIDTH{rs_val[WIDTH-1]}}, rs_val};
      extB    = {{WIDTH{rt_val[WIDTH-1]}}, rt_val};
      prodS   = extA * extB;
      prodU   = {{WIDTH{1'b0}}, rs_val} * {{WIDTH{1'b0}}, rt_val};
      accVal  = {hi_q, lo_q};
      divisor = (rt_val == '0) ? WIDTH'(1) : rt_val;
      quoU    = rs_val / divisor;
      remU    = rs_val % divisor;
      absA    = rs_val[WIDTH-1] ? -rs_val : rs_val;
      absB    = divisor[WIDTH-1] ? -divisor : divisor;
      quoMag  = absA / absB;
      remMag  = absA % absB;
      quoS    = (rs_val[WIDTH-1] ^ divisor[WIDTH-1]) ? -quoMag : quoMag;
      remS    = rs_val[WIDTH-1] ? -remMag : remMag;
      resultWe = 1'b1;
      result   = '0;
      case (op)
         OP_MULT:  result = prodS;
         OP_MULTU: result = prodU;
         OP_DIV:   begin result = {remS, quoS}; resultWe = (rt_val != '0); end
         OP_DIVU:  begin result = {remU, quoU}; resultWe = (rt_val != '0); end
         OP_MADD:  result = accVal + prodS;
         OP_MADDU: result = accVal + prodU;
         OP_MSUB:  result = accVal - prodS;
         OP_MSUBU: result = accVal - prodU;
         default:  result = '0;
      endcase
   end

   // Next-state: MTHI/MTLO write immediately, long ops park the result until the countdown ends.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      pend_d      = pend_q;
      pendValid_d = pendValid_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (op == OP_MTHI) begin
                  hi_d = rs_val;
               end else if (op == OP_MTLO) begin
                  lo_d = rs_val;
               end else if (isMul || isDiv) begin
                  pend_d      = result;
                  pendValid_d = resultWe;
                  cnt_d       = isDiv ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                  state_d     = RUN;
               end
            end
         end
         default: begin
            if (req) begin
               state_d     = IDLE;
               cnt_d       = '0;
               pend_d      = '0;
               pendValid_d = 1'b0;
            end else if (cnt_q == CW'(1)) begin
               if (pendValid_q) begin
                  hi_d = pend_q[2*WIDTH-1:WIDTH];
                  lo_d = pend_q[WIDTH-1:0];
               end
               state_d     = IDLE;
               cnt_d       = '0;
               pend_d      = '0;
               pendValid_d = 1'b0;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         pend_q      <= '0;
         pendValid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         pend_q      <= pend_d;
         pendValid_q <= pendValid_d;
      end
   end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multiply/divide unit with HI/LO registers, successor to the execute-stage HI/LO block.
- Sits in E stage. Takes forwarded rs/rt values and drives a stall request to the hazard controller.
- Adds configurable width and per-class latency, explicit start/busy handshake, exception abort, divide-by-zero and overflow rules.

Parameters:
WIDTH, 32, operand and HI/LO width
MULT_CYCLES, 5, busy cycles for multiply-class ops (>=1)
DIV_CYCLES, 10, busy cycles for divide ops (>=1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  E-stage instruction is an md op; valid this cycle
op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU
rs_val  input  WIDTH  forwarded rs operand
rt_val  input  WIDTH  forwarded rt operand
req  input  1  exception/interrupt taken this cycle; suppresses start and aborts in-flight op
rd_hi  input  1  read select: 1 HI, 0 LO
busy  output  1  operation in flight
stall  output  1  busy | (start & op in 1..4,7..10)
hi_out  output  WIDTH  HI register
lo_out  output  WIDTH  LO register
rdata  output  WIDTH  rd_hi ? hi_out : lo_out (combinational)

Behaviour:
- Reset (reset=0, async): HI=0, LO=0, state IDLE, counter=0, busy=0, pending result=0.
- States:
  - IDLE: accepts start.
  - RUN: counter counting down.
- Accept condition: start & !req & state IDLE. If start arrives while RUN, it is ignored; upstream holds the instruction via stall.
- MTHI/MTLO:
  - On accept, HI or LO <= rs_val at that edge. No busy.
  - The other register is unchanged.
- MULT/MULTU/DIV/DIVU/MADD*/MSUB*:
  - On accept, the full 2*WIDTH result is computed from operands latched at the start edge and stored in a pending register.
  - counter <= MULT_CYCLES or DIV_CYCLES. State -> RUN.
- RUN:
  - counter decrements each edge.
  - At the edge where counter==1: HI/LO <= pending, state -> IDLE.
  - busy is high for exactly N cycles after the start edge. New HI/LO are visible in the first cycle busy=0.
- Multiply:
  - MULT: signed {HI,LO} = rs*rt.
  - MULTU: unsigned {HI,LO} = rs*rt.
- Divide (truncating toward zero):
  - LO = quotient, HI = remainder. Remainder takes the sign of the dividend.
- Divide by zero (rt=0): op still occupies DIV_CYCLES; HI/LO unchanged at completion.
- Signed overflow (DIV, rs=100..0, rt=all ones): LO=100..0, HI=0.
- req handling:
  - req=1 in the same cycle as start: nothing accepted, no register change.
  - req=1 while RUN: abort. State -> IDLE next edge, HI/LO unchanged, pending discarded.
- Operand changes after the start edge have no effect.
- Reset asserted mid-operation: immediate return to reset values.
- Unused op codes 11..15, or op=0 with start: no effect.

Optional Feature:
- Macro MD_MADD_EN.
- When defined, ops 7..10 are supported:
  - MADD: signed {HI,LO} += rs*rt.
  - MADDU: unsigned {HI,LO} += rs*rt.
  - MSUB: signed {HI,LO} -= rs*rt.
  - MSUBU: unsigned {HI,LO} -= rs*rt.
  - All use MULT_CYCLES and 2*WIDTH wrap-around arithmetic.
  - The accumulator value is the HI/LO in place at the start edge.
- When undefined, ops 7..10 are treated as unused codes: no busy, stall=0, no register change.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=5, MULT_CYCLES=5 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1; rdata tracks rd_hi.
- DIVU rs=100, rt=7, DIV_CYCLES=10 -> after 10 busy cycles LO=14, HI=2. DIV rs=-7, rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Preload HI=0x11, LO=0x22 via MTHI/MTLO (no busy), then DIV rs=9, rt=0 -> 10 busy cycles; HI=0x11, LO=0x22 unchanged. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MULT 6*7, then req pulse on busy cycle 3 -> busy falls next edge, HI/LO keep prior values. start+MTHI with req=1 -> HI unchanged.
- Assert reset (low) during a DIV run -> busy=0 and HI=LO=0 immediately. start while busy with MTLO -> ignored; stall=1.
- With MD_MADD_EN, HI=0, LO=0xFFFFFFFF, MADDU 1*1 -> HI=1, LO=0. Without the macro, the same stimulus -> stall=0 and HI/LO unchanged.
